// File: rtl/mdio_receptor.sv
// PHY-side MDIO frame receiver clocked by the controller's mdc.
// Decodes the 16-bit header, then strobes a register write or serializes a register read.
module mdio_receptor #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        MDIO_DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_WR_DATA, S_RD_DATA, S_IGNORE, S_WAIT_LOW
  } state_t;

  state_t      state_r, state_nxt;
  logic [5:0]  cnt_r, cnt_nxt;
  logic [15:0] hdr_r, hdr_nxt;
  logic [15:0] dat_r, dat_nxt;
  logic [15:0] hdr_shift_s;
  logic [15:0] dat_shift_s;
  logic        in_nxt, in_oe_nxt, stb_nxt, done_nxt;
  logic [4:0]  addr_nxt;
  logic [15:0] wdata_nxt;
  logic        unused_s;

  assign hdr_shift_s = {hdr_r[14:0], MDIO_OUT};
  assign dat_shift_s = {dat_r[14:0], MDIO_OUT};
  // TA bits are never checked and the oldest header bit falls off the shifter
  assign unused_s    = ^{hdr_r[15], hdr_shift_s[1:0]};

  // State, counter, shifters and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 6'd0;
      hdr_r      <= 16'd0;
      dat_r      <= 16'd0;
      MDIO_IN    <= 1'b0;
      MDIO_IN_OE <= 1'b0;
      ADDR       <= 5'd0;
      WR_DATA    <= 16'd0;
      WR_STB     <= 1'b0;
      MDIO_DONE  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      hdr_r      <= hdr_nxt;
      dat_r      <= dat_nxt;
      MDIO_IN    <= in_nxt;
      MDIO_IN_OE <= in_oe_nxt;
      ADDR       <= addr_nxt;
      WR_DATA    <= wdata_nxt;
      WR_STB     <= stb_nxt;
      MDIO_DONE  <= done_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    hdr_nxt   = hdr_r;
    dat_nxt   = dat_r;
    in_nxt    = MDIO_IN;
    in_oe_nxt = MDIO_IN_OE;
    addr_nxt  = ADDR;
    wdata_nxt = WR_DATA;
    stb_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (MDIO_OE) begin
          hdr_nxt   = hdr_shift_s;
          cnt_nxt   = 6'd1;
          state_nxt = S_HEADER;
        end else begin
          cnt_nxt   = 6'd0;
        end
      end
      S_HEADER: begin
        if (MDIO_OE) begin
          hdr_nxt = hdr_shift_s;
          cnt_nxt = cnt_r + 6'd1;
          if (cnt_r == 6'd15) begin
            if ((hdr_shift_s[15:14] != 2'b01) || (hdr_shift_s[11:7] != PHY_ADDR) ||
                ((hdr_shift_s[13:12] != 2'b01) && (hdr_shift_s[13:12] != 2'b10))) begin
              state_nxt = S_IGNORE;
            end else if (hdr_shift_s[13:12] == 2'b01) begin
              state_nxt = S_WR_DATA;
            end else begin
              addr_nxt  = hdr_shift_s[6:2];
              state_nxt = S_RD_DATA;
            end
          end else begin
            state_nxt = S_HEADER;
          end
        end else begin
          cnt_nxt   = 6'd0;
          state_nxt = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (MDIO_OE) begin
          dat_nxt = dat_shift_s;
          cnt_nxt = cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            addr_nxt  = hdr_r[6:2];
            wdata_nxt = dat_shift_s;
            stb_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_WAIT_LOW;
          end else begin
            state_nxt = S_WR_DATA;
          end
        end else begin
          state_nxt = S_WAIT_LOW;
        end
      end
      S_RD_DATA: begin
        // MDIO_OE is deliberately ignored: the controller has released the line
        if (cnt_r == 6'd16) begin
          dat_nxt   = RD_DATA;
          in_nxt    = RD_DATA[15];
          in_oe_nxt = 1'b1;
          cnt_nxt   = cnt_r + 6'd1;
        end else if (cnt_r >= 6'd32) begin
          in_nxt    = 1'b0;
          in_oe_nxt = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = 6'd33;
          state_nxt = S_WAIT_LOW;
        end else begin
          in_nxt    = dat_r[14];
          dat_nxt   = {dat_r[14:0], 1'b0};
          cnt_nxt   = cnt_r + 6'd1;
        end
      end
      S_IGNORE: begin
        state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!MDIO_OE) begin
          cnt_nxt   = 6'd0;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT_LOW;
        end
      end
      default: begin
        cnt_nxt   = 6'd0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mdio_receptor.sv
// Directed bench for mdio_receptor: write, read, ignore, truncation and mid-frame reset.
module tb_mdio_receptor;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        mdio_in;
  logic        mdio_in_oe;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        mdio_done;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int done_cnt = 0;
  int inoe_cnt = 0;
  logic [15:0] rd_bits;

  always #5 clk = ~clk;

  // Register memory model: only address 7 holds data
  assign rd_data = (addr == 5'd7) ? 16'hBEEF : 16'h0000;

  mdio_receptor #(.PHY_ADDR(5'd1)) dut (
    .clk        (clk),
    .reset      (reset),
    .MDIO_OUT   (mdio_out),
    .MDIO_OE    (mdio_oe),
    .RD_DATA    (rd_data),
    .MDIO_IN    (mdio_in),
    .MDIO_IN_OE (mdio_in_oe),
    .ADDR       (addr),
    .WR_DATA    (wr_data),
    .WR_STB     (wr_stb),
    .MDIO_DONE  (mdio_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit at the falling edge, sample outputs just after the rising edge
  task automatic tick(input logic oe, input logic b);
    @(negedge clk);
    mdio_oe  = oe;
    mdio_out = b;
    @(posedge clk);
    #1;
    stb_cnt  += int'(wr_stb);
    done_cnt += int'(mdio_done);
    inoe_cnt += int'(mdio_in_oe);
  endtask

  task automatic send_bits(input logic [31:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) tick(1'b1, f[31-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    stb_cnt = 0; done_cnt = 0; inoe_cnt = 0;
  endtask

  task automatic do_read(input string tag);
    clear_counts();
    send_bits(32'h609C_0000, 16);
    check({tag, "_addr_e16"}, 32'(addr), 32'd7);
    rd_bits = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0);
      rd_bits = {rd_bits[14:0], mdio_in};
    end
    check({tag, "_bits"}, 32'(rd_bits), 32'h0000_BEEF);
    check({tag, "_inoe_cycles"}, 32'(inoe_cnt), 32'd16);
    tick(1'b0, 1'b0);
    check({tag, "_done_e33"}, 32'(mdio_done), 32'd1);
    check({tag, "_inoe_off"}, 32'(mdio_in_oe), 32'd0);
    idle(3);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_stb_count"}, 32'(stb_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_outputs", {10'd0, mdio_in, mdio_in_oe, addr, wr_data, wr_stb, mdio_done}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Valid write to register 3
    clear_counts();
    send_bits(32'h508E_A5C3, 32);
    check("wr_stb_e32", 32'(wr_stb), 32'd1);
    check("wr_done_e32", 32'(mdio_done), 32'd1);
    check("wr_addr", 32'(addr), 32'd3);
    check("wr_data", 32'(wr_data), 32'h0000_A5C3);
    idle(1);
    check("wr_stb_drop", 32'(wr_stb), 32'd0);
    idle(3);
    check("wr_stb_count", 32'(stb_cnt), 32'd1);
    check("wr_done_count", 32'(done_cnt), 32'd1);
    check("wr_inoe_count", 32'(inoe_cnt), 32'd0);

    do_read("rd");

    // PHY address mismatch, bad start, bad opcode
    clear_counts();
    send_bits(32'h510E_A5C3, 32); idle(2);
    send_bits(32'h108E_A5C3, 32); idle(2);
    send_bits(32'h708E_A5C3, 32); idle(2);
    check("ign_stb", 32'(stb_cnt), 32'd0);
    check("ign_done", 32'(done_cnt), 32'd0);
    check("ign_inoe", 32'(inoe_cnt), 32'd0);
    check("ign_wr_data_held", 32'(wr_data), 32'h0000_A5C3);

    // Valid write right after the ignored frames, register 5
    send_bits(32'h5096_1234, 32);
    check("post_ign_stb", 32'(wr_stb), 32'd1);
    check("post_ign_addr", 32'(addr), 32'd5);
    check("post_ign_data", 32'(wr_data), 32'h0000_1234);
    idle(2);

    // Truncated write after 20 bits
    clear_counts();
    send_bits(32'h508E_A5C3, 20); idle(3);
    check("trunc_stb", 32'(stb_cnt), 32'd0);
    check("trunc_done", 32'(done_cnt), 32'd0);
    check("trunc_wr_data", 32'(wr_data), 32'h0000_1234);
    send_bits(32'h508E_A5C3, 32);
    check("trunc_next_stb", 32'(wr_stb), 32'd1);
    check("trunc_next_data", 32'(wr_data), 32'h0000_A5C3);
    idle(2);

    // Reset in the middle of the read data phase
    clear_counts();
    send_bits(32'h609C_0000, 16);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
    check("mid_inoe_before", 32'(mdio_in_oe), 32'd1);
    check("mid_in_before", 32'(mdio_in), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_in", 32'(mdio_in), 32'd0);
    check("mid_rst_inoe", 32'(mdio_in_oe), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    idle(3);
    reset = 1'b1;
    idle(12);
    check("mid_rst_done", 32'(done_cnt), 32'd0);

    do_read("rd2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_receptor.md
# mdio_receptor

MDIO management-frame receiver (PHY side) that sits directly downstream of the MDIO transmitter/controller. It is clocked by the controller's `mdc`, and deserializes frames arriving on `MDIO_OUT` while `MDIO_OE` is high. It decodes the start, opcode, PHY address and register address, then either issues a write strobe to the register memory or serializes the addressed register back to the controller on `MDIO_IN`.

## Interface
- `PHY_ADDR`, default 5'd1: PHY address this receiver answers to.
- `clk` input 1: the controller's `mdc`. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low. Asserting it clears all state immediately.
- `MDIO_OUT` input 1: serial frame bit from the controller, MSB first.
- `MDIO_OE` input 1: high while the controller is driving a valid frame bit.
- `RD_DATA` input 16: register memory read data. Combinational from `ADDR`.
- `MDIO_IN` output 1: serial read data back to the controller.
- `MDIO_IN_OE` output 1: high while `MDIO_IN` carries read data.
- `ADDR` output 5: register address for the memory.
- `WR_DATA` output 16: write data for the memory.
- `WR_STB` output 1: one-cycle write strobe.
- `MDIO_DONE` output 1: one-cycle pulse when a valid transaction completes.

## Operation
- Frame layout, 32 bits, MSB first:
  - bits 31:30 ST (must be 01)
  - bits 29:28 OP (01 = write, 10 = read)
  - bits 27:23 PHYAD
  - bits 22:18 REGAD
  - bits 17:16 TA (not checked)
  - bits 15:0 DATA
- Registers: `state`, a 6-bit bit counter `cnt`, a 16-bit header shift register, and a 16-bit data shift register.
- States: IDLE, HEADER, WR_DATA, RD_DATA, IGNORE, WAIT_LOW.
- IDLE to HEADER:
  - The first edge with `MDIO_OE`=1 samples bit 31 and sets `cnt`=1.
  - IDLE is entered only after `MDIO_OE` has been seen low on at least one edge (see WAIT_LOW).
- HEADER:
  - Each edge with `MDIO_OE`=1 shifts in `MDIO_OUT` and increments `cnt`.
  - `MDIO_OE`=0 before 16 bits: go to IDLE. No outputs change.
- Header decode happens on the edge that samples the 16th bit (E16):
  - ST≠01, OP∉{01,10}, or PHYAD≠`PHY_ADDR`: go to IGNORE.
  - OP=01: go to WR_DATA.
  - OP=10: `ADDR`<=REGAD and go to RD_DATA.
- WR_DATA:
  - Shift in 16 bits on E17..E32 while `MDIO_OE`=1.
  - At E32: `ADDR`<=REGAD, `WR_DATA`<=collected data, `WR_STB`<=1, `MDIO_DONE`<=1, then go to WAIT_LOW.
  - `MDIO_OE`=0 before the 32nd bit: abort to WAIT_LOW. No strobe, no done.
- RD_DATA (`MDIO_OE` is ignored in this state):
  - E17: load the data shift register with `RD_DATA`, set `MDIO_IN`<=`RD_DATA`[15] and `MDIO_IN_OE`<=1.
  - E18..E32: `MDIO_IN` carries bits 14..0 in order.
  - E33: `MDIO_IN`<=0, `MDIO_IN_OE`<=0, `MDIO_DONE`<=1, then go to WAIT_LOW.
- IGNORE: hold all outputs. Go to WAIT_LOW on the next edge.
- WAIT_LOW: go to IDLE on the first edge with `MDIO_OE`=0.
- Reset values, all taking effect immediately on `reset`=0:
  - `MDIO_IN`=0, `MDIO_IN_OE`=0, `ADDR`=0, `WR_DATA`=0, `WR_STB`=0, `MDIO_DONE`=0.
  - `state`=IDLE, `cnt`=0, both shift registers 0.
- Reset in the middle of a frame discards the frame. No strobe or done is issued for it.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Write latency: `WR_STB` and `MDIO_DONE` are high during the cycle after E32, for exactly one cycle.
- Read:
  - `ADDR` is valid from E16.
  - `RD_DATA` must settle within one cycle.
  - The 16 data bits appear in the cycles following E17..E32.
  - `MDIO_DONE` is high for one cycle after E33.
- `ADDR` and `WR_DATA` hold their last values until the next valid transaction.
- `cnt` never exceeds 33. It resets to 0 on entry to IDLE.

## Test plan
- Write: `PHY_ADDR`=1, frame 0x508EA5C3 with `MDIO_OE` high for 32 cycles.
  - Expect `ADDR`=3, `WR_DATA`=0xA5C3, and `WR_STB` and `MDIO_DONE` each high for exactly one cycle after E32.
  - `MDIO_IN_OE` stays 0 throughout.
- Read: header 0x609C over 16 cycles, with the memory model returning 0xBEEF for `ADDR`=7.
  - Expect `ADDR`=7 from E16.
  - Expect `MDIO_IN`=1011111011101111 across E17..E32 with `MDIO_IN_OE` high for 16 cycles.
  - Expect `MDIO_DONE` pulsed after E33.
- PHYAD mismatch: frame 0x510EA5C3.
  - Expect no `WR_STB`, no `MDIO_DONE`, `MDIO_IN_OE`=0.
  - Expect return to IDLE after `MDIO_OE` falls.
- Bad ST/OP: frames with ST=00, and with OP=11.
  - Both ignored, with no output activity.
  - A valid write immediately afterwards completes normally.
- Truncated write: `MDIO_OE` drops after 20 bits of 0x508EA5C3.
  - Expect no `WR_STB`, and `WR_DATA` unchanged.
  - The next full frame is accepted.
- Reset mid-read: `reset` asserted at E24.
  - Expect `MDIO_IN`, `MDIO_IN_OE` and `ADDR` at 0 immediately, with no `MDIO_DONE`.
  - After release, a new read works.
